regression_sample_reader: RTL

Read-side sequencer for the linear-regression sample memories. After a start pulse it scans addresses 0..N-1 of the x and y sample memories and streams the (x, y) pairs, in address order, to the downstream accumulator over a valid/ready interface. It sits between the x/y sample memories and the regression arithmetic, and is the read counterpart of the parallel memory-load path. A 2-entry output buffer absorbs the memory read latency, so backpressure never drops or duplicates a sample.

---
 rtl/regression_sample_reader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/regression_sample_reader.sv
// regression_sample_reader
// Scans addresses 0..N-1 of the x/y sample memories and streams the
// (x, y) pairs in address order to the regression accumulator.
// mem_addr is a register: an address launched at one clock edge is
// captured from mem_x/mem_y at the following edge into a 2-entry buffer.
// Reads are only launched when the buffer is guaranteed to have room for
// the returning data, so backpressure never drops or duplicates a pair.
//
// Stream handshake: s_valid is high whenever the buffer holds a pair; a
// pair transfers on any rising edge where s_valid & s_ready are both 1.
// While s_valid is high and s_ready is low, s_x/s_y/s_last are held
// stable; s_valid never drops without a completed transfer.
module regression_sample_reader #(
    parameter int N  = 150,
    parameter int DW = 20,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_x,
    input  logic [DW-1:0] mem_y,
    output logic          s_valid,
    input  logic          s_ready,
    output logic [DW-1:0] s_x,
    output logic [DW-1:0] s_y,
    output logic          s_last,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Index of the final sample, held one bit wider than the address so
    // that N = 2^AW is detected on the issued count rather than on wrap.
    localparam logic [AW:0] LAST_IDX = (AW+1)'(N - 1);
    localparam logic        ONE_SAMPLE = (N == 1);

    state_t        state_q;
    logic [AW:0]   issued_q;         // number of reads launched this scan
    logic [AW-1:0] addr_q;           // address of the most recent read
    logic          inflight_q;       // a read was launched at the last edge
    logic          inflight_last_q;  // ...and it was the read of N-1
    logic          busy_q;
    logic          done_q;

    logic [DW-1:0] fx_q [0:1];
    logic [DW-1:0] fy_q [0:1];
    logic          fl_q [0:1];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;

    logic          push;
    logic          pop;
    logic          room;

    assign push = inflight_q;
    assign pop  = (count_q != 2'd0) && s_ready;

    // A new read may launch only if buffered + returning entries stay <= 2
    // after this edge; a pop at this edge frees one slot.
    assign room = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    // Next buffer occupancy: push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Scan sequencer: launches reads, tracks the last one, pulses done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            issued_q        <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // The read of address 0 launches with the start edge.
                        addr_q          <= '0;
                        issued_q        <= (AW+1)'(1);
                        inflight_q      <= 1'b1;
                        inflight_last_q <= ONE_SAMPLE;
                        busy_q          <= 1'b1;
                        state_q         <= ONE_SAMPLE ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (room) begin
                        addr_q          <= issued_q[AW-1:0];
                        issued_q        <= issued_q + (AW+1)'(1);
                        inflight_q      <= 1'b1;
                        inflight_last_q <= (issued_q == LAST_IDX);
                        if (issued_q == LAST_IDX) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last pair is the final entry ever pushed, so its
                    // acceptance also means the buffer and read path are empty.
                    if (pop && fl_q[rd_q]) begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output buffer: capture returning read data, advance head on handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fx_q[0] <= '0;
            fx_q[1] <= '0;
            fy_q[0] <= '0;
            fy_q[1] <= '0;
            fl_q[0] <= 1'b0;
            fl_q[1] <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                fx_q[wr_q] <= mem_x;
                fy_q[wr_q] <= mem_y;
                fl_q[wr_q] <= inflight_last_q;
                wr_q       <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
        end
    end

    assign mem_addr  = addr_q;
    assign s_valid   = (count_q != 2'd0);
    assign s_x       = fx_q[rd_q];
    assign s_y       = fy_q[rd_q];
    assign s_last    = fl_q[rd_q];
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
